// File: rtl/cpu_pkg.sv
// Shared constants and types for the fetch front end.
// Imported by pc_unit and pc_stack.
package cpu_pkg;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_SIZE        = 32;
  localparam int DEF_STACK_DEPTH = 4;
  localparam int RESET_PC        = 0;

  typedef enum logic [1:0] {
    OP_INC,
    OP_JMP,
    OP_CALL,
    OP_RET
  } pc_op_e;

  typedef struct packed {
    logic ovf;
    logic unf;
    logic addr;
  } pc_err_t;

  function automatic pc_op_e pick_op(
    input logic jmp,
    input logic call,
    input logic ret
  );
    pc_op_e op;
    op = OP_INC;
    if (ret)
      op = OP_RET;
    else if (call)
      op = OP_CALL;
    else if (jmp)
      op = OP_JMP;
    return op;
  endfunction

endpackage

// File: rtl/pc_stack.sv
// Return-address LIFO for pc_unit.
// Only the pointer is reset; entry contents are don't-care.
module pc_stack
  import cpu_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_STACK_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int DW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_top,
  output logic             o_full,
  output logic             o_empty,
  output logic [DW-1:0]    o_depth
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DW-1:0]    r_ptr;

  logic             w_full;
  logic             w_empty;
  logic             w_do_push;
  logic             w_do_pop;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_rd_idx;

  assign w_full    = (r_ptr == DW'(DEPTH));
  assign w_empty   = (r_ptr == '0);
  assign w_do_pop  = i_pop & ~w_empty;
  assign w_do_push = i_push & ~w_full & ~i_pop;
  assign w_wr_idx  = r_ptr[AW-1:0];
  assign w_rd_idx  = AW'(r_ptr - DW'(1));

  // Occupancy pointer; pop beats push if both arrive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ptr <= '0;
    else if (w_do_pop)
      r_ptr <= r_ptr - DW'(1);
    else if (w_do_push)
      r_ptr <= r_ptr + DW'(1);
  end

  // Entry storage, written at the current pointer on push.
  always_ff @(posedge clk) begin
    if (w_do_push)
      r_mem[w_wr_idx] <= i_data;
  end

  assign o_top   = r_mem[w_rd_idx];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_depth = r_ptr;

endmodule

// File: rtl/pc_unit.sv
// Fetch-address generator feeding a combinational ROM.
// Sequential/jump/call/return with sticky control-flow error flags.
module pc_unit
  import cpu_pkg::*;
#(
  parameter  int WIDTH       = DEF_WIDTH,
  parameter  int SIZE        = DEF_SIZE,
  parameter  int STACK_DEPTH = DEF_STACK_DEPTH,
  localparam int DW          = $clog2(STACK_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             jmp,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] addr,
  output logic [DW-1:0]    depth,
  output logic             err_ovf,
  output logic             err_unf,
  output logic             err_addr
);

  localparam logic [WIDTH:0]   SIZE_W = (WIDTH+1)'(SIZE);
  localparam logic [WIDTH-1:0] LAST   = WIDTH'(SIZE - 1);
  localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_PC);

  logic [WIDTH-1:0] r_addr;
  pc_err_t          r_err;

  pc_op_e           w_op;
  logic [WIDTH-1:0] w_seq;
  logic             w_tgt_ok;
  logic [WIDTH-1:0] w_addr_d;
  pc_err_t          w_err_set;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_top;
  logic             w_full;
  logic             w_empty;
  logic [DW-1:0]    w_depth;

  assign w_op     = pick_op(jmp, call, ret);
  assign w_seq    = (r_addr == LAST) ? '0 : r_addr + WIDTH'(1);
  assign w_tgt_ok = ({1'b0, target} < SIZE_W);

  // Next address, stack request and error set for this cycle.
  always_comb begin
    w_addr_d  = r_addr;
    w_err_set = '0;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    unique case (w_op)
      OP_RET: begin
        if (w_empty) begin
          w_err_set.unf = 1'b1;
        end else begin
          w_pop    = en;
          w_addr_d = w_top;
        end
      end
      OP_CALL: begin
        if (w_full) begin
          w_err_set.ovf = 1'b1;
        end else if (!w_tgt_ok) begin
          w_err_set.addr = 1'b1;
        end else begin
          w_push   = en;
          w_addr_d = target;
        end
      end
      OP_JMP: begin
        if (w_tgt_ok)
          w_addr_d = target;
        else
          w_err_set.addr = 1'b1;
      end
      default: begin
        w_addr_d = w_seq;
      end
    endcase
  end

  // PC and sticky flags; stalled cycles leave everything intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= RST_PC;
      r_err  <= '0;
    end else if (en) begin
      r_addr <= w_addr_d;
      r_err  <= r_err | w_err_set;
    end
  end

  pc_stack #(
    .WIDTH (WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_seq),
    .o_top   (w_top),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_depth (w_depth)
  );

  assign addr     = r_addr;
  assign depth    = w_depth;
  assign err_ovf  = r_err.ovf;
  assign err_unf  = r_err.unf;
  assign err_addr = r_err.addr;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit.
// Directed table, hand sequences and a random run against a model.
module tb_pc_unit;
  import cpu_pkg::*;

  localparam int W  = DEF_WIDTH;
  localparam int SZ = DEF_SIZE;
  localparam int SD = DEF_STACK_DEPTH;
  localparam int DW = $clog2(SD) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en, jmp, call, ret;
  logic [W-1:0]  target;
  logic [W-1:0]  addr;
  logic [DW-1:0] depth;
  logic          err_ovf, err_unf, err_addr;

  int n_checks = 0;
  int n_errors = 0;

  int m_addr;
  int m_stk[$];
  bit m_eo, m_eu, m_ea;

  typedef struct {
    logic       en, jmp, call, ret;
    int         tgt;
    int         e_addr;
    int         e_depth;
    logic [2:0] e_err;
  } vec_t;

  vec_t vecs[16];

  always #5 clk = ~clk;

  pc_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .jmp      (jmp),
    .call     (call),
    .ret      (ret),
    .target   (target),
    .addr     (addr),
    .depth    (depth),
    .err_ovf  (err_ovf),
    .err_unf  (err_unf),
    .err_addr (err_addr)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic j, input logic c,
                       input logic r, input int t);
    en = e; jmp = j; call = c; ret = r; target = W'(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    m_addr = 0;
    m_stk.delete();
    m_eo = 0; m_eu = 0; m_ea = 0;
  endtask

  function automatic logic [2:0] errs();
    return {err_ovf, err_unf, err_addr};
  endfunction

  function automatic void model_step(input bit e, input bit j,
                                     input bit c, input bit r,
                                     input int t);
    if (!e) return;
    if (r) begin
      if (m_stk.size() == 0) m_eu = 1;
      else m_addr = m_stk.pop_back();
    end else if (c) begin
      if (m_stk.size() == SD) m_eo = 1;
      else if (t >= SZ) m_ea = 1;
      else begin
        m_stk.push_back((m_addr + 1) % SZ);
        m_addr = t;
      end
    end else if (j) begin
      if (t >= SZ) m_ea = 1;
      else m_addr = t;
    end else begin
      m_addr = (m_addr + 1) % SZ;
    end
  endfunction

  initial begin
    //            en j  c  r  tgt addr d  {o,u,a}
    vecs[0]  = '{1, 1, 0, 0,  5,  5, 0, 3'b000};
    vecs[1]  = '{1, 1, 0, 0, 20, 20, 0, 3'b000};
    vecs[2]  = '{1, 0, 0, 0,  0, 21, 0, 3'b000};
    vecs[3]  = '{1, 1, 0, 0, 40, 21, 0, 3'b001};
    vecs[4]  = '{1, 1, 0, 0,  3,  3, 0, 3'b001};
    vecs[5]  = '{1, 0, 1, 0, 10, 10, 1, 3'b001};
    vecs[6]  = '{1, 0, 0, 1,  0,  4, 0, 3'b001};
    vecs[7]  = '{1, 0, 1, 0, 10, 10, 1, 3'b001};
    vecs[8]  = '{1, 1, 1, 1,  7,  5, 0, 3'b001};
    vecs[9]  = '{0, 0, 1, 0,  9,  5, 0, 3'b001};
    vecs[10] = '{1, 1, 0, 0, 31, 31, 0, 3'b001};
    vecs[11] = '{1, 0, 1, 0,  2,  2, 1, 3'b001};
    vecs[12] = '{1, 0, 0, 1,  0,  0, 0, 3'b001};
    vecs[13] = '{1, 0, 0, 1,  0,  0, 0, 3'b011};
    vecs[14] = '{1, 0, 1, 0, 32,  0, 0, 3'b011};
    vecs[15] = '{0, 1, 0, 0, 12,  0, 0, 3'b011};

    // Reset values and sequential wrap at SIZE.
    do_reset();
    chk("rst_addr", addr, 0);
    chk("rst_depth", depth, 0);
    chk("rst_err", errs(), 0);
    drive(1, 0, 0, 0, 0);
    for (int k = 1; k <= 35; k++) begin
      tick();
      chk($sformatf("seq%0d", k), addr, k % SZ);
    end
    chk("seq_err", errs(), 0);

    // Directed table.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].en, vecs[i].jmp, vecs[i].call,
            vecs[i].ret, vecs[i].tgt);
      tick();
      chk($sformatf("vec%0d_addr", i), addr, vecs[i].e_addr);
      chk($sformatf("vec%0d_depth", i), depth, vecs[i].e_depth);
      chk($sformatf("vec%0d_err", i), errs(), vecs[i].e_err);
    end

    // Fill stack, overflow, LIFO unwind, underflow.
    do_reset();
    drive(1, 0, 1, 0, 10); tick(); chk("n1", addr, 10);
    drive(1, 0, 1, 0, 20); tick(); chk("n2", addr, 20);
    drive(1, 0, 1, 0, 30); tick(); chk("n3", addr, 30);
    drive(1, 0, 1, 0,  5); tick(); chk("n4", addr, 5);
    chk("n4_depth", depth, 4);
    chk("n4_err", errs(), 3'b000);
    drive(1, 0, 1, 0,  8); tick();
    chk("ovf_addr", addr, 5);
    chk("ovf_depth", depth, 4);
    chk("ovf_err", errs(), 3'b100);
    drive(1, 0, 0, 1, 0);
    tick(); chk("r1", addr, 31); chk("r1_d", depth, 3);
    tick(); chk("r2", addr, 21); chk("r2_d", depth, 2);
    tick(); chk("r3", addr, 11); chk("r3_d", depth, 1);
    tick(); chk("r4", addr, 1);  chk("r4_d", depth, 0);
    tick();
    chk("unf_addr", addr, 1);
    chk("unf_err", errs(), 3'b110);

    // Async reset mid-sequence, no clock edge needed.
    do_reset();
    drive(1, 1, 0, 0, 31); tick();
    drive(1, 0, 1, 0, 40); tick();
    drive(1, 0, 1, 0, 6);  tick();
    chk("pre_rst_addr", addr, 6);
    chk("pre_rst_err", errs(), 3'b001);
    drive(1, 0, 0, 1, 0);
    rst_n = 1'b0;
    #1;
    chk("async_addr", addr, 0);
    chk("async_depth", depth, 0);
    chk("async_err", errs(), 0);
    #2;
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);

    // Random run against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic e, j, c, r;
      int t;
      if (i % 150 == 149) begin
        do_reset();
        chk("rnd_rst", {addr, 5'(depth), errs()}, 0);
      end
      e = ($urandom_range(0, 7) != 0);
      r = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 3) == 0);
      j = ($urandom_range(0, 3) == 0);
      t = ($urandom_range(0, 7) == 0) ? $urandom_range(SZ, 255)
                                      : $urandom_range(0, SZ - 1);
      drive(e, j, c, r, t);
      tick();
      model_step(e, j, c, r, t);
      chk($sformatf("rnd%0d_addr", i), addr, m_addr);
      chk($sformatf("rnd%0d_depth", i), depth, m_stk.size());
      chk($sformatf("rnd%0d_err", i), errs(), {m_eo, m_eu, m_ea});
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
